// File: rtl/param_piso_serializer_pkg.sv
// Purpose: shared frame-FSM state encoding and a width helper for the serializer family.
// Latency: none (types and compile-time function only).
// Backpressure: not applicable.
package param_piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } frameState_t;

  // Bits needed to hold values 0..value-1; callers pass count+1 to hold 0..count.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Purpose: down-counter of bits remaining in a frame, with parallel load and last-bit flag.
// Latency: load/decrement take effect at the next clk edge; isLast is combinational from count.
// Backpressure: none; decrement is simply held off while dec is low and saturates at zero.
module frame_bit_counter
  import param_piso_serializer_pkg::*;
#(
  parameter int MAX_COUNT = 8,
  localparam int CNT_W    = clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             isLast
);

  // Load wins over decrement so a back-to-back frame restarts the count cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign isLast = (count == CNT_W'(1));

endmodule

// File: rtl/param_piso_serializer.sv
// Purpose: WIDTH-bit parallel-in/serial-out shifter with simultaneous serial capture and framing.
// Latency: first bit on shift_out the cycle after load accept; done one cycle after the last shift edge.
// Backpressure: load_ready only in IDLE or on the last-bit edge (shift_en high); shift_en gaps hold the frame.
module param_piso_serializer
  import param_piso_serializer_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CNT_W     = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_left,
  output logic [WIDTH-1:0] reg_content
);

  frameState_t      state;
  frameState_t      stateNext;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shiftNext;
  logic             isLast;
  logic             inShift;
  logic             doShift;
  logic             lastEdge;
  logic             acceptLoad;

  assign inShift    = (state == ST_SHIFT);
  assign doShift    = inShift && shift_en;
  assign lastEdge   = doShift && isLast;
  assign acceptLoad = load_valid && load_ready;

  // On a back-to-back load the counter reloads instead of stepping down to zero.
  frame_bit_counter #(
    .MAX_COUNT (WIDTH)
  ) u_bitCounter (
    .clk       (clk),
    .rst       (rst),
    .load      (acceptLoad),
    .loadValue (CNT_W'(WIDTH)),
    .dec       (doShift && !acceptLoad),
    .count     (bits_left),
    .isLast    (isLast)
  );

  // Frame FSM: next state and load_ready; ready in SHIFT only on the final bit tick.
  always_comb begin
    stateNext  = state;
    load_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        load_ready = lastEdge;
        if (lastEdge && !load_valid) begin
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Shift datapath: a new word replaces the register (dropping the last capture), else shift on tick.
  always_comb begin
    shiftNext = shiftReg;
    if (acceptLoad) begin
      shiftNext = par_in;
    end else if (doShift) begin
      if (MSB_FIRST) begin
        shiftNext = {shiftReg[WIDTH-2:0], shift_in};
      end else begin
        shiftNext = {shift_in, shiftReg[WIDTH-1:1]};
      end
    end
  end

  // State, shift register and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shiftReg <= '0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      done     <= lastEdge;
    end
  end

  assign busy        = inShift;
  assign shift_valid = inShift;
  assign shift_out   = MSB_FIRST ? shiftReg[WIDTH-1] : shiftReg[0];
  assign reg_content = shiftReg;

endmodule

// File: tb/tb_param_piso_serializer.sv
// Purpose: self-checking bench for param_piso_serializer, MSB-first and LSB-first instances side by side.
// Latency: inputs driven 1 time unit after posedge, outputs compared mid-cycle before the next edge.
// Backpressure: producer holds load_valid until the bench-side model sees it accepted.
module tb_param_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] par_in;
  logic         load_valid;
  logic         shift_en;
  logic         shift_in;

  logic         readyM, outM, validM, busyM, doneM;
  logic [3:0]   leftM;
  logic [W-1:0] regM;
  logic         readyL, outL, validL, busyL, doneL;
  logic [3:0]   leftL;
  logic [W-1:0] regL;

  always #5 clk = ~clk;

  param_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid), .load_ready(readyM),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(outM), .shift_valid(validM),
    .busy(busyM), .done(doneM), .bits_left(leftM), .reg_content(regM)
  );

  param_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid), .load_ready(readyL),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(outL), .shift_valid(validL),
    .busy(busyL), .done(doneL), .bits_left(leftL), .reg_content(regL)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each register is a queue of bits ordered from the output end.
  bit qM[$];
  bit qL[$];
  bit mBusy;
  bit mDone;
  int mLeft;

  bit capture[$];
  int doneSeen;
  int readyBusySeen;

  typedef struct {
    bit           lv;
    logic [W-1:0] pin;
    bit           se;
    bit           si;
    bit           eOut;
    bit           eDone;
    bit           eBusy;
    bit           eReady;
    int           eLeft;
    logic [W-1:0] eRegM;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    qM.delete();
    qL.delete();
    for (int i = 0; i < W; i++) begin
      qM.push_back(1'b0);
      qL.push_back(1'b0);
    end
    mBusy = 1'b0;
    mDone = 1'b0;
    mLeft = 0;
  endtask

  task automatic setIn(input bit r, input bit lv, input logic [W-1:0] p, input bit se, input bit si);
    rst        = r;
    load_valid = lv;
    par_in     = p;
    shift_en   = se;
    shift_in   = si;
  endtask

  function automatic logic [31:0] capWord();
    logic [31:0] w;
    w = '0;
    foreach (capture[i]) w = {w[30:0], capture[i]};
    return w;
  endfunction

  task automatic modelCheck();
    bit           expReady;
    logic [W-1:0] expRegM;
    logic [W-1:0] expRegL;
    expReady = !mBusy || (mLeft == 1 && shift_en);
    for (int i = 0; i < W; i++) begin
      expRegM[W-1-i] = qM[i];
      expRegL[i]     = qL[i];
    end
    chk("ready_msb", 32'(readyM), 32'(expReady));
    chk("ready_lsb", 32'(readyL), 32'(expReady));
    chk("out_msb",   32'(outM),   32'(qM[0]));
    chk("out_lsb",   32'(outL),   32'(qL[0]));
    chk("valid_msb", 32'(validM), 32'(mBusy));
    chk("valid_lsb", 32'(validL), 32'(mBusy));
    chk("busy_msb",  32'(busyM),  32'(mBusy));
    chk("busy_lsb",  32'(busyL),  32'(mBusy));
    chk("done_msb",  32'(doneM),  32'(mDone));
    chk("done_lsb",  32'(doneL),  32'(mDone));
    chk("left_msb",  32'(leftM),  32'(mLeft));
    chk("left_lsb",  32'(leftL),  32'(mLeft));
    chk("reg_msb",   32'(regM),   32'(expRegM));
    chk("reg_lsb",   32'(regL),   32'(expRegL));
    if (doneM) doneSeen++;
    if (busyM && readyM) readyBusySeen++;
  endtask

  // Advance one clock and apply the frame rules to the model with the inputs held across the edge.
  task automatic tick();
    bit lastE;
    bit acc;
    if (!rst && mBusy && shift_en) capture.push_back(outM);
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      lastE = mBusy && shift_en && (mLeft == 1);
      acc   = load_valid && (!mBusy || lastE);
      mDone = lastE;
      if (acc) begin
        qM.delete();
        qL.delete();
        for (int i = 0; i < W; i++) begin
          qM.push_back(par_in[W-1-i]);
          qL.push_back(par_in[i]);
        end
        mLeft = W;
        mBusy = 1'b1;
      end else if (mBusy && shift_en) begin
        void'(qM.pop_front());
        void'(qL.pop_front());
        qM.push_back(shift_in);
        qL.push_back(shift_in);
        mLeft--;
        if (mLeft == 0) mBusy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit lv, input logic [W-1:0] p, input bit se, input bit si);
    setIn(r, lv, p, se, si);
    #2;
    modelCheck();
    tick();
  endtask

  initial begin
    bit           pat[8];
    logic [W-1:0] regSeq[10];
    bit           outSeq[8];
    int           enabled;

    pat    = '{1, 1, 0, 0, 1, 1, 0, 0};
    outSeq = '{1, 0, 1, 0, 0, 1, 0, 1};
    regSeq = '{8'h00, 8'hA5, 8'h4B, 8'h97, 8'h2E, 8'h5C, 8'hB9, 8'h73, 8'hE6, 8'hCC};

    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h00};
    for (int k = 1; k <= 8; k++) begin
      tbl[k] = '{1'b0, 8'h00, 1'b1, pat[k-1], outSeq[k-1], 1'b0, 1'b1, (k == 8), 9 - k, regSeq[k]};
    end
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'hCC};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'hCC};

    // Power-up reset, unchecked until the model is aligned.
    setIn(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    modelReset();
    #1;

    // Frame of 0xA5 with continuous tick; both bit orders yield 1,0,1,0,0,1,0,1.
    for (int i = 0; i < 11; i++) begin
      setIn(1'b0, tbl[i].lv, tbl[i].pin, tbl[i].se, tbl[i].si);
      #2;
      modelCheck();
      chk("tbl_out_msb", 32'(outM),  32'(tbl[i].eOut));
      chk("tbl_out_lsb", 32'(outL),  32'(tbl[i].eOut));
      chk("tbl_done",    32'(doneM), 32'(tbl[i].eDone));
      chk("tbl_busy",    32'(busyM), 32'(tbl[i].eBusy));
      chk("tbl_ready",   32'(readyM), 32'(tbl[i].eReady));
      chk("tbl_left_msb", 32'(leftM), 32'(tbl[i].eLeft));
      chk("tbl_left_lsb", 32'(leftL), 32'(tbl[i].eLeft));
      chk("tbl_reg_msb", 32'(regM),  32'(tbl[i].eRegM));
      tick();
    end
    chk("frame_reg_lsb", 32'(regL), 32'h33);

    // Gapped tick pattern 1,0,0,1,0,0,... must not alter the bit stream.
    capture.delete();
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    enabled = 0;
    for (int i = 0; i < 60 && enabled < 8; i++) begin
      step(1'b0, 1'b0, '0, (i % 3 == 0), 1'($urandom));
      if (i % 3 == 0) enabled++;
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("gap_stream", capWord(), 32'h3C);

    // Back-to-back frames 0x0F then 0xF0 with load_valid held.
    capture.delete();
    doneSeen      = 0;
    readyBusySeen = 0;
    step(1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hF0, 1'b1, 1'($urandom));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b2b_stream", capWord(), 32'h0FF0);
    chk("b2b_done_count", 32'(doneSeen), 32'd2);
    chk("b2b_ready_count", 32'(readyBusySeen), 32'd2);

    // Reset mid-frame, then a clean frame of 0x81.
    step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    setIn(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("rst_reg", 32'(regM), 32'h0);
    chk("rst_left", 32'(leftM), 32'h0);
    chk("rst_busy", 32'(busyM), 32'h0);
    chk("rst_done", 32'(doneM), 32'h0);
    chk("rst_ready", 32'(readyM), 32'h1);
    modelCheck();
    tick();
    capture.delete();
    step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_stream", capWord(), 32'h81);

    // Load offered mid-frame (bits_left=4) is ignored.
    capture.delete();
    step(1'b0, 1'b1, 8'h96, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    setIn(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    #2;
    chk("midframe_left", 32'(leftM), 32'd4);
    chk("midframe_ready", 32'(readyM), 32'h0);
    modelCheck();
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("midframe_stream", capWord(), 32'h96);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), W'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
